// File: rtl/shift_decode_if.sv
// Handshake bundle between the issue logic and the shift decode stage:
// an op request channel (in_*) and a decoded op channel for the shift chain (out_*).
interface shift_decode_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;

  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [SHAMT_W-1:0] out_en;
  logic               out_fill;
  logic               out_rev;
  logic               out_illegal;

  // Upstream issuer and downstream chain side (drives requests, accepts decoded ops).
  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_en, out_fill, out_rev, out_illegal
  );

  // Decode stage side.
  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_en, out_fill, out_rev, out_illegal
  );
endinterface

// File: rtl/shift_decode_stage.sv
// Registered issue/decode stage ahead of the right-shift chain, with a two-entry skid buffer.
// Optional stall counter enabled by defining SHIFT_STALL_CNT_EN.
module shift_decode_stage #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              flush,
  shift_decode_if.slave     bus
`ifdef SHIFT_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] en;
    logic               fill;
    logic               rev;
    logic               illegal;
  } dec_t;

  state_e state_q, state_d;
  dec_t   main_q, main_d;
  dec_t   skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  dec_t   in_dec;
  logic   in_fire, out_fire, out_valid;

  // Left shifts are bit-reversed here so the chain only ever shifts right.
  function automatic dec_t decode(input logic [DATA_W-1:0]  d,
                                  input logic [SHAMT_W-1:0] s,
                                  input logic [1:0]         op);
    dec_t r;
    r.data    = d;
    r.en      = s;
    r.fill    = 1'b0;
    r.rev     = 1'b0;
    r.illegal = 1'b0;
    case (op_e'(op))
      OP_SLL: begin
        for (int i = 0; i < DATA_W; i++) r.data[i] = d[DATA_W-1-i];
        r.rev = 1'b1;
      end
      OP_SRA:  r.fill = d[DATA_W-1];
      OP_RSV: begin
        r.en      = '0;
        r.illegal = 1'b1;
      end
      default: ;
    endcase
    return r;
  endfunction

  assign in_dec    = decode(bus.in_data, bus.in_shamt, bus.in_op);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = bus.in_valid & in_ready_q;
  assign out_fire  = out_valid & bus.out_ready;

  // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_dec;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_dec;
        end else if (in_fire) begin
          skid_d  = in_dec;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    in_ready_d = (state_d != FULL);
  end

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
    end
  end

  // NOTE: the skid entry is never visible before it is written, so it carries no reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = main_q.data;
  assign bus.out_en      = main_q.en;
  assign bus.out_fill    = main_q.fill;
  assign bus.out_rev     = main_q.rev;
  assign bus.out_illegal = main_q.illegal;

`ifdef SHIFT_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush)
      stall_cnt_d = '0;
    else if (out_valid && !bus.out_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_shift_decode_stage.sv
// Scoreboard bench for shift_decode_stage: driver pushes expected decoded ops, a
// negedge monitor compares the presented op and handshake state against the queue.
module tb_shift_decode_stage;
  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  logic clk = 1'b0;
  logic n_rst;
  logic flush;
  always #5 clk = ~clk;

  shift_decode_if #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) bus ();

`ifdef SHIFT_STALL_CNT_EN
  logic [15:0] stall_cnt;
  int          stall_model = 0;
`endif

  shift_decode_stage #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .flush (flush),
    .bus   (bus)
`ifdef SHIFT_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] en;
    logic               fill;
    logic               rev;
    logic               illegal;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;
  logic last_fire;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the chain needs to see for each op kind.
  function automatic exp_t model(input logic [DATA_W-1:0] d, input logic [SHAMT_W-1:0] s,
                                 input logic [1:0] op);
    logic [DATA_W-1:0] mirrored;
    exp_t e;
    for (int i = 0; i < DATA_W; i++) mirrored[DATA_W-1-i] = d[i];
    case (op)
      2'd0:    e = '{data: mirrored, en: s,  fill: 1'b0,       rev: 1'b1, illegal: 1'b0};
      2'd1:    e = '{data: d,        en: s,  fill: 1'b0,       rev: 1'b0, illegal: 1'b0};
      2'd2:    e = '{data: d,        en: s,  fill: d[DATA_W-1], rev: 1'b0, illegal: 1'b0};
      default: e = '{data: d,        en: '0, fill: 1'b0,       rev: 1'b0, illegal: 1'b1};
    endcase
    return e;
  endfunction

  // One clock: sample handshake at negedge, commit the model at the posedge, return at posedge+1.
  task automatic step();
    logic fire, fl, rs;
    logic [DATA_W-1:0] d;
    logic [SHAMT_W-1:0] s;
    logic [1:0] op;
    @(negedge clk);
    fire = bus.in_valid && bus.in_ready;
    fl = flush; rs = n_rst;
    d = bus.in_data; s = bus.in_shamt; op = bus.in_op;
    @(posedge clk);
    if (!rs || fl) q.delete();
    else if (fire) q.push_back(model(d, s, op));
    last_fire = fire;
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [SHAMT_W-1:0] s,
                       input logic [1:0] op, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_shamt  = s;
    bus.in_op     = op;
    bus.out_ready = ordy;
    flush         = fl;
    step();
  endtask

  task automatic send_hold(input logic [DATA_W-1:0] d, input logic [SHAMT_W-1:0] s,
                           input logic [1:0] op, input logic ordy);
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, d, s, op, ordy, 1'b0);
      if (last_fire) return;
    end
    check("accept_timeout", 64'd0, 64'd1);
  endtask

  // Monitor: occupancy-derived handshake checks and in-order comparison of the head op.
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", {63'd0, bus.out_valid}, {63'd0, q.size() != 0});
      check("in_ready", {63'd0, bus.in_ready}, {63'd0, q.size() < 2});
      if (bus.out_valid && q.size() > 0) begin
        check("out_op", 64'({bus.out_data, bus.out_en, bus.out_fill, bus.out_rev, bus.out_illegal}),
              64'(q[0]));
        if (bus.out_ready) void'(q.pop_front());
      end
`ifdef SHIFT_STALL_CNT_EN
      check("stall_cnt", 64'(stall_cnt), 64'(stall_model));
      if (!n_rst || flush) stall_model = 0;
      else if (bus.out_valid && !bus.out_ready && stall_model < 16'hFFFF) stall_model++;
`endif
    end
  end

  initial begin
    n_rst = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_shamt = '0; bus.in_op = '0;
    bus.out_ready = 1'b0;
    step();
    mon_en = 1'b1;
    step();
    n_rst = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 2'd0, 1'b1, 1'b0);
      check("idle_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("idle_out_en", 64'(bus.out_en), 64'd0);
    end

    // SRA example.
    drive(1'b1, 32'h8000_00F0, 5'd5, 2'd2, 1'b1, 1'b0);
    check("sra_valid", {63'd0, bus.out_valid}, 64'd1);
    check("sra_en", 64'(bus.out_en), 64'h5);
    check("sra_fill", {63'd0, bus.out_fill}, 64'd1);
    check("sra_rev", {63'd0, bus.out_rev}, 64'd0);
    check("sra_data", 64'(bus.out_data), 64'h8000_00F0);

    // SLL example.
    drive(1'b1, 32'h0000_0001, 5'd3, 2'd0, 1'b1, 1'b0);
    check("sll_data", 64'(bus.out_data), 64'h8000_0000);
    check("sll_rev", {63'd0, bus.out_rev}, 64'd1);
    check("sll_fill", {63'd0, bus.out_fill}, 64'd0);
    check("sll_en", 64'(bus.out_en), 64'h3);

    // Reserved op.
    drive(1'b1, 32'h1234_5678, 5'd7, 2'd3, 1'b1, 1'b0);
    check("ill_flag", {63'd0, bus.out_illegal}, 64'd1);
    check("ill_en", 64'(bus.out_en), 64'd0);
    check("ill_data", 64'(bus.out_data), 64'h1234_5678);
    drive(1'b0, '0, '0, 2'd0, 1'b1, 1'b0);

    // Backpressure: third op is held upstream until the chain drains.
    send_hold(32'h0000_0011, 5'd1, 2'd1, 1'b0);
    send_hold(32'h0000_0022, 5'd2, 2'd1, 1'b0);
    check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    drive(1'b1, 32'h0000_0033, 5'd3, 2'd1, 1'b0, 1'b0);
    check("bp_held", {63'd0, last_fire}, 64'd0);
    send_hold(32'h0000_0033, 5'd3, 2'd1, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 2'd0, 1'b1, 1'b0);
    check("bp_drained", {63'd0, bus.out_valid}, 64'd0);

    // Stall count over four stalled cycles, starting from a flushed counter.
    drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b1);
    send_hold(32'hA5A5_0000, 5'd9, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
`ifdef SHIFT_STALL_CNT_EN
    check("stall_cnt_4", 64'(stall_cnt), 64'd4);
`endif

    // FULL then flush with a concurrent request that must be discarded.
    send_hold(32'h5A5A_0000, 5'd4, 2'd0, 1'b0);
    check("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
    drive(1'b1, 32'hDEAD_BEEF, 5'd1, 2'd1, 1'b0, 1'b1);
    check("flush_valid", {63'd0, bus.out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 2'd0, 1'b1, 1'b0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      n_rst = ($urandom_range(0, 199) != 0);
      drive(1'b1 & ($urandom_range(0, 3) != 0), $urandom, 5'($urandom), 2'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
    end
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 2'd0, 1'b1, 1'b0);
    check("final_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
